lfa_motor_controller: RTL and testbench

Parametrised line-follower decision and drive block for an N-channel sensor array. It consumes per-channel ADC samples from the ADC controller, thresholds them with hysteresis, and runs a debounced steering FSM with junction counting and lost-line recovery. It drives the four motor-driver inputs with PWM. It replaces the fixed three-channel, full-on motor control between the ADC controller and the motor driver pins.

---
 rtl/lfa_pkg.sv | 19 +
 rtl/lfa_pwm_gen.sv | 16 +
 rtl/lfa_motor_controller.sv | 129 ++++++++++++
 tb/tb_lfa_motor_controller.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/lfa_pkg.sv
// lfa_pkg: shared state encoding, motor bundle and channel helpers for the line follower
package lfa_pkg;
  typedef enum logic [2:0] {
    FORWARD  = 3'd0,
    LEFT     = 3'd1,
    RIGHT    = 3'd2,
    STOP     = 3'd3,
    JUNCTION = 3'd4
  } state_t;
  typedef struct packed {
    logic a;
    logic b;
    logic c;
    logic d;
  } motor_t;
  function automatic int center(input int num_ch);
    return num_ch / 2;
  endfunction
endpackage

// File: rtl/lfa_pwm_gen.sv
// lfa_pwm_gen: free-running PWM counter, output high while counter < duty
module lfa_pwm_gen #(
  parameter int PWM_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [PWM_W-1:0] duty,
  output logic             pwm_out
);
  logic [PWM_W-1:0] cnt;
  always_ff @(posedge clk)
    if (reset) cnt <= '0;
    else if (en) cnt <= cnt + 1'b1;
  assign pwm_out = cnt < duty;
endmodule

// File: rtl/lfa_motor_controller.sv
// lfa_motor_controller: hysteresis line detect, debounced steering FSM and PWM motor drive
module lfa_motor_controller
  import lfa_pkg::*;
#(
  parameter int NUM_CH      = 3,
  parameter int DATA_W      = 12,
  parameter int THRESH_HI   = 2048,
  parameter int THRESH_LO   = 1536,
  parameter int PWM_W       = 8,
  parameter int DUTY_FWD    = 200,
  parameter int DUTY_TURN   = 150,
  parameter int JN_DEBOUNCE = 4,
  parameter int JN_HOLD     = 8,
  parameter int LOST_LIMIT  = 16,
  parameter int JCNT_W      = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     sample_valid,
  input  logic [NUM_CH*DATA_W-1:0] sample_data,
  input  logic                     pause,
  output logic                     a,
  output logic                     b,
  output logic                     c,
  output logic                     d,
  output logic [2:0]               state,
  output logic [JCNT_W-1:0]        junction_count,
  output logic                     junction_pulse
);
  localparam int CTR = center(NUM_CH);
  localparam int JW = $clog2(JN_DEBOUNCE + 1);
  localparam int HW = $clog2(JN_HOLD + 1);
  localparam int LW = $clog2(LOST_LIMIT + 1);
  localparam logic [DATA_W-1:0] HI = DATA_W'(THRESH_HI);
  localparam logic [DATA_W-1:0] LO = DATA_W'(THRESH_LO);
  logic                     in_valid, line_valid;
  logic [NUM_CH*DATA_W-1:0] in_data;
  logic [NUM_CH-1:0]        line, line_nxt;
  logic                     grp_l, grp_r, grp_all, grp_none;
  state_t                   st;
  logic [JW-1:0]            jn_run;
  logic [HW-1:0]            hold;
  logic [LW-1:0]            lost_run, lost_nxt;
  logic                     pwm_fwd, pwm_turn;
  motor_t                   drv, drv_nxt;
  always_ff @(posedge clk)
    if (reset) begin
      in_valid <= 1'b0;
      in_data <= '0;
    end else if (!pause) begin
      in_valid <= sample_valid;
      in_data <= sample_data;
    end
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [DATA_W-1:0] s;
    assign s = in_data[i*DATA_W +: DATA_W];
    assign line_nxt[i] = s >= HI ? 1'b1 : s <= LO ? 1'b0 : line[i];
  end
  always_ff @(posedge clk)
    if (reset) begin
      line <= '0;
      line_valid <= 1'b0;
    end else if (!pause) begin
      line_valid <= in_valid;
      if (in_valid) line <= line_nxt;
    end
  assign grp_l = |line[CTR-1:0];
  assign grp_r = |line[NUM_CH-1:CTR+1];
  assign grp_all = &line;
  assign grp_none = ~|line;
  assign lost_nxt = lost_run == LW'(LOST_LIMIT) ? lost_run : lost_run + 1'b1;
  // steering state only changes on a sample slot; sensors are ignored during the junction hold
  always_ff @(posedge clk)
    if (reset) begin
      st <= STOP;
      jn_run <= '0;
      lost_run <= '0;
      hold <= '0;
      junction_count <= '0;
      junction_pulse <= 1'b0;
    end else begin
      junction_pulse <= 1'b0;
      if (!pause && line_valid) begin
        if (st == JUNCTION) begin
          hold <= hold + 1'b1;
          if (hold == HW'(JN_HOLD - 1)) begin
            st <= FORWARD;
            hold <= '0;
          end
        end else if (grp_all) begin
          lost_run <= '0;
          if (jn_run == JW'(JN_DEBOUNCE - 1)) begin
            st <= JUNCTION;
            jn_run <= '0;
            hold <= '0;
            junction_pulse <= 1'b1;
            if (junction_count != '1) junction_count <= junction_count + 1'b1;
          end else jn_run <= jn_run + 1'b1;
        end else if (grp_none) begin
          jn_run <= '0;
          lost_run <= lost_nxt;
          if (lost_nxt == LW'(LOST_LIMIT)) st <= STOP;
        end else begin
          jn_run <= '0;
          lost_run <= '0;
          st <= grp_l && !grp_r ? LEFT : grp_r && !grp_l ? RIGHT : FORWARD;
        end
      end
    end
  lfa_pwm_gen #(.PWM_W(PWM_W)) u_pwm_fwd (
    .clk(clk), .reset(reset), .en(!pause), .duty(PWM_W'(DUTY_FWD)), .pwm_out(pwm_fwd)
  );
  lfa_pwm_gen #(.PWM_W(PWM_W)) u_pwm_turn (
    .clk(clk), .reset(reset), .en(!pause), .duty(PWM_W'(DUTY_TURN)), .pwm_out(pwm_turn)
  );
  always_comb begin
    drv_nxt = '0;
    drv_nxt.a = (st == FORWARD || st == JUNCTION) ? pwm_fwd : st == RIGHT ? pwm_turn : 1'b0;
    drv_nxt.c = (st == FORWARD || st == JUNCTION) ? pwm_fwd : st == LEFT ? pwm_turn : 1'b0;
  end
  always_ff @(posedge clk)
    if (reset) drv <= '0;
    else drv <= pause ? '0 : drv_nxt;
  assign a = drv.a;
  assign b = drv.b;
  assign c = drv.c;
  assign d = drv.d;
  assign state = st;
endmodule

// File: tb/tb_lfa_motor_controller.sv
// tb_lfa_motor_controller: directed scoreboard bench for the line follower controller
module tb_lfa_motor_controller;
  import lfa_pkg::*;
  typedef struct {
    logic [2:0] st;
    logic       p;
    logic [3:0] jc;
  } exp_t;
  localparam logic [11:0] H = 12'd3000;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sample_valid = 1'b0;
  logic [35:0] sample_data = '0;
  logic        pause = 1'b0;
  logic        a, b, c, d;
  logic [2:0]  state;
  logic [3:0]  junction_count;
  logic        junction_pulse;
  exp_t        q[$];
  int          checks = 0;
  int          errors = 0;
  int          jc = 0;
  lfa_motor_controller dut (
    .clk(clk), .reset(reset), .sample_valid(sample_valid), .sample_data(sample_data),
    .pause(pause), .a(a), .b(b), .c(c), .d(d), .state(state),
    .junction_count(junction_count), .junction_pulse(junction_pulse)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic pop_check();
    exp_t e;
    if (q.size() == 0) begin
      check("scoreboard_empty", 32'd1, 32'd0);
      return;
    end
    e = q.pop_front();
    check("state", 32'(state), 32'(e.st));
    check("junction_pulse", 32'(junction_pulse), 32'(e.p));
    check("junction_count", 32'(junction_count), 32'(e.jc));
  endtask
  task automatic expect_next(input logic [2:0] es, input logic ep);
    if (ep && jc != 15) jc++;
    q.push_back('{es, ep, 4'(jc)});
  endtask
  task automatic send(input logic [11:0] l, input logic [11:0] cc, input logic [11:0] r,
                      input logic [2:0] es, input logic ep);
    expect_next(es, ep);
    sample_data = {r, cc, l};
    sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
    tick();
    tick();
    pop_check();
  endtask
  task automatic duty(input int ea, input int ec);
    int na = 0, nc = 0, nbd = 0;
    tick();
    for (int k = 0; k < 256; k++) begin
      tick();
      na += int'(a);
      nc += int'(c);
      nbd += int'(b | d);
    end
    check("duty_a", 32'(na), 32'(ea));
    check("duty_c", 32'(nc), 32'(ec));
    check("duty_bd", 32'(nbd), 32'd0);
  endtask
  task automatic junction_event();
    for (int k = 0; k < 3; k++) send(H, H, H, FORWARD, 1'b0);
    send(H, H, H, JUNCTION, 1'b1);
    send(H, H, H, JUNCTION, 1'b0);
    for (int k = 0; k < 6; k++) send(0, 0, 0, JUNCTION, 1'b0);
    send(0, H, 0, FORWARD, 1'b0);
  endtask
  initial begin
    sample_data = {H, H, H};
    tick();
    tick();
    sample_valid = 1'b1;
    tick();
    reset = 1'b0;
    sample_valid = 1'b0;
    check("reset_state", 32'(state), 32'(STOP));
    check("reset_abcd", 32'({a, b, c, d}), 32'd0);
    check("reset_jcount", 32'(junction_count), 32'd0);
    check("reset_pulse", 32'(junction_pulse), 32'd0);
    for (int k = 0; k < 4; k++) tick();
    check("reset_discards_sample", 32'(state), 32'(STOP));
    send(0, H, 0, FORWARD, 1'b0);
    duty(200, 200);
    send(H, 0, 0, LEFT, 1'b0);
    duty(0, 150);
    send(12'd1800, 0, 0, LEFT, 1'b0);
    send(12'd1536, 12'd2048, 0, FORWARD, 1'b0);
    send(12'd2048, 12'd1537, 0, LEFT, 1'b0);
    send(12'd2047, 12'd2047, 12'd2047, LEFT, 1'b0);
    send(0, H, 0, FORWARD, 1'b0);
    for (int k = 0; k < 3; k++) send(H, H, H, FORWARD, 1'b0);
    send(H, H, H, JUNCTION, 1'b1);
    tick();
    check("pulse_one_cycle", 32'(junction_pulse), 32'd0);
    send(H, H, H, JUNCTION, 1'b0);
    for (int k = 0; k < 6; k++) send(0, 0, 0, JUNCTION, 1'b0);
    send(0, H, 0, FORWARD, 1'b0);
    send(0, 0, H, RIGHT, 1'b0);
    for (int k = 0; k < 5; k++) send(0, 0, 0, RIGHT, 1'b0);
    send(0, 0, H, RIGHT, 1'b0);
    for (int k = 0; k < 15; k++) send(0, 0, 0, RIGHT, 1'b0);
    send(0, 0, 0, STOP, 1'b0);
    duty(0, 0);
    send(0, H, 0, FORWARD, 1'b0);
    expect_next(LEFT, 1'b0);
    expect_next(RIGHT, 1'b0);
    expect_next(FORWARD, 1'b0);
    sample_valid = 1'b1;
    sample_data = {12'd0, 12'd0, H};
    tick();
    sample_data = {H, 12'd0, 12'd0};
    tick();
    sample_data = {12'd0, H, 12'd0};
    tick();
    sample_valid = 1'b0;
    pop_check();
    tick();
    pop_check();
    tick();
    pop_check();
    tick();
    pause = 1'b1;
    tick();
    check("pause_abcd", 32'({a, b, c, d}), 32'd0);
    check("pause_state", 32'(state), 32'(FORWARD));
    send(H, 0, 0, FORWARD, 1'b0);
    begin
      int na = 0;
      for (int k = 0; k < 20; k++) begin
        tick();
        na += int'(a | c);
      end
      check("pause_drive_low", 32'(na), 32'd0);
    end
    pause = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    check("pause_sample_ignored", 32'(state), 32'(FORWARD));
    duty(200, 200);
    for (int k = 0; k < 19; k++) junction_event();
    check("jcount_saturated", 32'(junction_count), 32'd15);
    for (int k = 0; k < 3; k++) send(H, H, H, FORWARD, 1'b0);
    send(H, H, H, JUNCTION, 1'b1);
    send(0, 0, 0, JUNCTION, 1'b0);
    send(0, 0, 0, JUNCTION, 1'b0);
    reset = 1'b1;
    tick();
    check("midjn_reset_state", 32'(state), 32'(STOP));
    check("midjn_reset_abcd", 32'({a, b, c, d}), 32'd0);
    check("midjn_reset_jcount", 32'(junction_count), 32'd0);
    check("midjn_reset_pulse", 32'(junction_pulse), 32'd0);
    reset = 1'b0;
    jc = 0;
    send(0, H, 0, FORWARD, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
